// File: rtl/flash_apb_ctrl.sv
// APB flash-array slave: bit-clearing program, sector erase to all ones, wait-state
// handshaking while busy, CTRL/STATUS/ERASE register window and a completion pulse.
module flash_apb_ctrl #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 8,
    parameter int SECTOR_W     = 4,
    parameter int PROG_CYCLES  = 4,
    parameter int ERASE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              apb_sel,
    input  logic              apb_enable,
    input  logic              apb_write,
    input  logic [ADDR_W:0]   apb_addr,
    input  logic [DATA_W-1:0] apb_wdata,
    output logic [DATA_W-1:0] apb_rdata,
    output logic              apb_ready,
    output logic              apb_slverr,
    output logic              busy,
    output logic              irq_done
);
    localparam int DEPTH        = 1 << ADDR_W;
    localparam int SECTOR_WORDS = 1 << SECTOR_W;
    localparam int SEC_IDX_W    = ADDR_W - SECTOR_W;
    localparam int CNT_MAX      = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int CNT_W        = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROG  = 2'd1,
        ST_ERASE = 2'd2
    } state_t;

    logic [DATA_W-1:0]    mem [DEPTH];
    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic                 busy_r, irq_done_r, wen_r, mismatch_r, rd_wait_r;
    logic [DATA_W-1:0]    rdata_r, rd_value_s;
    logic [ADDR_W-1:0]    prog_addr_r;
    logic [DATA_W-1:0]    prog_data_r;
    logic [SEC_IDX_W-1:0] erase_sector_r;

    logic       access_s, is_reg_s, blocked_s, wr_go_s, rd_go_s, rd_done_s;
    logic       wr_err_s, rd_err_s, start_prog_s, start_erase_s, commit_s, prog_miss_s;
    logic [1:0] offset_s;

    assign access_s  = apb_sel & apb_enable;
    assign is_reg_s  = apb_addr[ADDR_W];
    assign offset_s  = apb_addr[1:0];
    // STATUS/CTRL reads, ERASE reads and reserved accesses pass through while busy.
    assign blocked_s = busy_r & (~is_reg_s | (apb_write & ((offset_s == 2'd1) | (offset_s == 2'd2))));
    assign wr_go_s   = access_s & apb_write & ~blocked_s & ~reset;
    assign rd_go_s   = access_s & ~apb_write & ~blocked_s & ~rd_wait_r & ~reset;
    assign rd_done_s = access_s & ~apb_write & rd_wait_r & ~reset;
    assign wr_err_s  = is_reg_s ? ((offset_s == 2'd3) | ((offset_s == 2'd2) & ~wen_r)) : ~wen_r;
    assign rd_err_s  = is_reg_s & (offset_s == 2'd3);

    assign start_prog_s  = wr_go_s & ~is_reg_s & wen_r;
    assign start_erase_s = wr_go_s & is_reg_s & (offset_s == 2'd2) & wen_r;
    assign prog_miss_s   = |(prog_data_r & ~mem[prog_addr_r]);

    assign apb_rdata = rdata_r;
    assign busy      = busy_r;
    assign irq_done  = irq_done_r;

    // Read-data source mux for the capture cycle.
    always_comb begin
        rd_value_s = {DATA_W{1'b0}};
        if (!is_reg_s) begin
            rd_value_s = mem[apb_addr[ADDR_W-1:0]];
        end else begin
            case (offset_s)
                2'd0: begin
                    rd_value_s[0] = busy_r;
                    rd_value_s[1] = wen_r;
                    rd_value_s[2] = mismatch_r;
                end
                2'd1:    rd_value_s[0] = wen_r;
                default: rd_value_s = {DATA_W{1'b0}};
            endcase
        end
    end

    // Transfer completion and error response.
    always_comb begin
        apb_ready  = 1'b0;
        apb_slverr = 1'b0;
        if (wr_go_s) begin
            apb_ready  = 1'b1;
            apb_slverr = wr_err_s;
        end else if (rd_done_s) begin
            apb_ready  = 1'b1;
            apb_slverr = rd_err_s;
        end else begin
            apb_ready  = 1'b0;
            apb_slverr = 1'b0;
        end
    end

    // Next-state logic; the commit happens in the cycle the counter is already zero.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        commit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_prog_s) begin
                    state_s = ST_PROG;
                    cnt_s   = CNT_W'(PROG_CYCLES - 1);
                end else if (start_erase_s) begin
                    state_s = ST_ERASE;
                    cnt_s   = CNT_W'(ERASE_CYCLES - 1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PROG, ST_ERASE: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s  = ST_IDLE;
                    commit_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, busy and completion pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            irq_done_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            busy_r     <= (state_s != ST_IDLE);
            irq_done_r <= commit_s;
        end
    end

    // Control/status registers, operation latches and the read wait-state capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            wen_r          <= 1'b0;
            mismatch_r     <= 1'b0;
            rd_wait_r      <= 1'b0;
            rdata_r        <= {DATA_W{1'b0}};
            prog_addr_r    <= {ADDR_W{1'b0}};
            prog_data_r    <= {DATA_W{1'b0}};
            erase_sector_r <= {SEC_IDX_W{1'b0}};
        end else begin
            if (wr_go_s && is_reg_s && (offset_s == 2'd1)) begin
                wen_r <= apb_wdata[0];
                if (apb_wdata[1]) begin
                    mismatch_r <= 1'b0;
                end
            end
            if (commit_s && (state_r == ST_PROG) && prog_miss_s) begin
                mismatch_r <= 1'b1;
            end
            if (start_prog_s) begin
                prog_addr_r <= apb_addr[ADDR_W-1:0];
                prog_data_r <= apb_wdata;
            end
            if (start_erase_s) begin
                erase_sector_r <= apb_wdata[SEC_IDX_W-1:0];
            end
            if (rd_go_s) begin
                rd_wait_r <= 1'b1;
                rdata_r   <= rd_value_s;
            end else if (rd_done_s || !access_s) begin
                rd_wait_r <= 1'b0;
            end
        end
    end

    // Array storage; contents deliberately survive reset and an aborted operation never commits.
    always_ff @(posedge clk) begin
        if (!reset && commit_s) begin
            if (state_r == ST_PROG) begin
                mem[prog_addr_r] <= mem[prog_addr_r] & prog_data_r;
            end else begin
                for (int i = 0; i < SECTOR_WORDS; i++) begin
                    mem[{erase_sector_r, i[SECTOR_W-1:0]}] <= {DATA_W{1'b1}};
                end
            end
        end
    end
endmodule

// File: doc/flash_apb_ctrl.md
Name: flash_apb_ctrl

Overview:
Parametrised APB flash-array slave with flash-style semantics:
- programming can only clear bits;
- sector erase sets a sector to all ones;
- program and erase are multi-cycle busy operations with wait-state handshaking.

It adds a small control/status register window, write-enable protection, error responses and a completion interrupt. It sits on the APB side of the AHB-APB bridge as the next-generation flash slave.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 8, array word-address width; depth = 2^ADDR_W words.
- SECTOR_W, 4, log2 words per sector; SECTOR_W < ADDR_W.
- PROG_CYCLES, 4, busy cycles per program; >= 1.
- ERASE_CYCLES, 16, busy cycles per sector erase; >= 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- apb_sel  input  1  slave select.
- apb_enable  input  1  access phase.
- apb_write  input  1  1 = write, 0 = read.
- apb_addr  input  ADDR_W+1  bit ADDR_W = 0 selects the array (low bits = word address); bit ADDR_W = 1 selects registers (low 2 bits = offset).
- apb_wdata  input  DATA_W  write data.
- apb_rdata  output  DATA_W  read data, valid when apb_ready=1 on a read.
- apb_ready  output  1  transfer completes this cycle.
- apb_slverr  output  1  error response, valid only with apb_ready.
- busy  output  1  program or erase in progress.
- irq_done  output  1  one-cycle pulse when a program or erase commits.

Behaviour:
- Reset (synchronous): apb_rdata=0, apb_ready=0, apb_slverr=0, busy=0, irq_done=0, WEN=0, mismatch=0, state IDLE, counter 0. Array contents are not reset.
- Register map (offset when apb_addr[ADDR_W]=1):
  - 0 STATUS, RO: [0] busy, [1] WEN, [2] mismatch (sticky); other bits 0.
  - 1 CTRL: write [0] = WEN, write [1] = 1 clears mismatch. Read returns WEN in [0].
  - 2 ERASE, WO: write the sector index in low ADDR_W-SECTOR_W bits to start an erase. Reads return 0.
  - 3 reserved: slverr=1; reads return 0; no effect.
- Phases: setup = sel & !enable; access = sel & enable. apb_ready and apb_slverr are 0 outside access.
- Blocking: while busy=1, any array access, ERASE write or CTRL write holds apb_ready=0 until busy=0. STATUS and CTRL reads are never blocked.
- Writes: apb_ready=1 in the first unblocked access cycle. Array writes are posted.
- Reads: exactly one wait state after the first unblocked access cycle. apb_rdata is registered in that cycle; apb_ready=1 the following cycle.
- State machine: IDLE -> PROG on an accepted array write with WEN=1; IDLE -> ERASE on an accepted ERASE write with WEN=1. Both return to IDLE after the busy count.
- Counter: loaded with PROG_CYCLES-1 or ERASE_CYCLES-1. busy=1 from the cycle after acceptance through the cycle in which the counter reaches 0.
- Commit occurs in the last busy cycle:
  - Program: mem[a] <= mem[a] & wdata; mismatch |= |(wdata & ~mem[a]).
  - Erase: every word of the sector <= all ones.
  - irq_done pulses in the cycle after commit, coincident with busy falling.
- Address and data are latched at acceptance. apb_addr and apb_wdata changes during busy have no effect.
- WEN=0 on an array write or ERASE write: ready with slverr=1, no operation, busy stays 0.
- Array reads never error.
- Reset mid-operation: operation aborted, no commit, array unchanged, no irq_done.
- CTRL write in the commit cycle cannot occur: CTRL writes are blocked while busy.
- A mismatch clear arriving in the same cycle a commit sets mismatch cannot occur, for the same reason.

Test Plan:
Defaults apply to all scenarios.
- Erase sector 0: write CTRL=0x1, then ERASE=0 -> busy high 16 cycles, irq_done pulses once, busy falls; read array 0x05 -> 0xFFFFFFFF with ready on the 2nd access cycle, slverr=0.
- Program: write array 0x05 = 0x12345678 -> ready on the 1st access cycle, busy 4 cycles; read 0x05 -> 0x12345678. Then program 0x05 = 0x0000FFFF -> read 0x00005678; STATUS = 0x6. Write CTRL = 0x3 -> STATUS = 0x2.
- Protection: write CTRL=0, then program 0x06 = 0 -> ready=1, slverr=1, busy stays 0, 0x06 unchanged. Same for an ERASE write.
- Blocking: issue a read of 0x05 in the cycle after a program of 0x05 = 0x0000FF00 is accepted -> ready low during busy, rises one cycle after busy falls, data 0x00005600. A STATUS read during busy completes with one wait, bit0=1.
- Reset mid-erase: program 0x10 = 0x0, start erase of sector 1, assert reset at busy cycle 8 -> busy=0, no irq_done, STATUS=0. After re-enabling, read 0x10 -> 0x00000000.
- Reserved offset: read offset 3 -> ready with slverr=1, rdata=0. Write offset 3 -> slverr=1, no state change.
